simple_mem_copy_dma: RTL

Bus-initiator copy engine for the Simple_Mem bus. It drives the read and write channels that memory-mapped peripherals such as GPIO and RAM respond on. Given a source address, a destination address and a word count, it copies 32-bit words one at a time: it reads a word, then writes it, then advances both addresses. A per-access response timeout reports unmapped or hung targets.

---
 rtl/simple_mem_copy_dma.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/simple_mem_copy_dma.sv
// Word-at-a-time memory copy engine for the Simple_Mem bus.
// Each word is read, then written, then both addresses advance by 4.
// Every wait for a ready pulse is bounded, and a timeout is reported with
// the address of the access that was left hanging.
module simple_mem_copy_dma #(
  parameter int TIMEOUT = 255,
  parameter int LEN_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] word_count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      err_addr,
  output logic [31:0]      rd_addr,
  output logic [3:0]       rd_byteEn,
  output logic             rd_valid,
  input  logic             rd_ready,
  input  logic [31:0]      rd_data,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic [3:0]       wr_byteEn,
  output logic             wr_valid,
  input  logic             wr_ready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4
  } state_t;

  // Last wait cycle in which a ready pulse is still accepted.
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT);

  state_t           state_reg,    state_next;
  logic [31:0]      rd_addr_reg,  rd_addr_next;
  logic [31:0]      wr_addr_reg,  wr_addr_next;
  logic [31:0]      data_reg,     data_next;
  logic [LEN_W-1:0] cnt_reg,      cnt_next;
  logic [7:0]       wait_reg,     wait_next;
  logic             done_reg,     done_next;
  logic             err_reg,      err_next;
  logic [31:0]      err_addr_reg, err_addr_next;

  logic rd_req;
  logic wr_req;

  // Register all state; reset returns every output and counter to zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      rd_addr_reg  <= '0;
      wr_addr_reg  <= '0;
      data_reg     <= '0;
      cnt_reg      <= '0;
      wait_reg     <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      rd_addr_reg  <= rd_addr_next;
      wr_addr_reg  <= wr_addr_next;
      data_reg     <= data_next;
      cnt_reg      <= cnt_next;
      wait_reg     <= wait_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      err_addr_reg <= err_addr_next;
    end
  end

  // Next-state logic: sequence read/write per word, bound each wait, honour abort.
  always_comb begin
    state_next    = state_reg;
    rd_addr_next  = rd_addr_reg;
    wr_addr_next  = wr_addr_reg;
    data_next     = data_reg;
    cnt_next      = cnt_reg;
    wait_next     = wait_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    err_addr_next = err_addr_reg;

    if (abort && (state_reg != IDLE)) begin
      // Drop the transfer silently; an already issued valid pulse stays issued.
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              state_next   = RD_REQ;
              rd_addr_next = src_addr;
              wr_addr_next = dst_addr;
              cnt_next     = word_count;
            end else begin
              done_next = 1'b1;
            end
          end
        end
        RD_REQ: begin
          wait_next  = 8'd1;
          state_next = RD_WAIT;
        end
        RD_WAIT: begin
          if (rd_ready) begin
            data_next  = rd_data;
            state_next = WR_REQ;
          end else if (wait_reg == WAIT_LIMIT) begin
            state_next    = IDLE;
            err_next      = 1'b1;
            err_addr_next = rd_addr_reg;
          end else begin
            wait_next = wait_reg + 8'd1;
          end
        end
        WR_REQ: begin
          wait_next  = 8'd1;
          state_next = WR_WAIT;
        end
        WR_WAIT: begin
          if (wr_ready) begin
            cnt_next     = cnt_reg - 1'b1;
            rd_addr_next = rd_addr_reg + 32'd4;
            wr_addr_next = wr_addr_reg + 32'd4;
            if (cnt_reg == LEN_W'(1)) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = RD_REQ;
            end
          end else if (wait_reg == WAIT_LIMIT) begin
            state_next    = IDLE;
            err_next      = 1'b1;
            err_addr_next = wr_addr_reg;
          end else begin
            wait_next = wait_reg + 8'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign rd_req = (state_reg == RD_REQ);
  assign wr_req = (state_reg == WR_REQ);

  // Byte enables follow their valid: all lanes during a request, none otherwise.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_en
      assign rd_byteEn[gi] = rd_req;
      assign wr_byteEn[gi] = wr_req;
    end
  endgenerate

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign err      = err_reg;
  assign err_addr = err_addr_reg;
  assign rd_addr  = rd_addr_reg;
  assign rd_valid = rd_req;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = data_reg;
  assign wr_valid = wr_req;

endmodule
